hamming_frame_ctrl: RTL and testbench

Sequences the 100-entry Hamming window coefficient ROM (7-bit address, 16-bit unsigned Q0.15 coefficient, 1-cycle registered read) across one frame of input samples. Each accepted sample is multiplied by its window coefficient. The windowed frame is streamed out with a last marker.
Sits between the input sample FIFO and the downstream FFT/processing stage in fifo_in_out. It is the only master of the window ROM.

---
 rtl/hamming_frame_ctrl_pkg.sv | 20 ++
 rtl/hamming_frame_ctrl_win_mul_round.sv | 30 +++
 rtl/hamming_frame_ctrl.sv | 119 +++++++++++
 tb/tb_hamming_frame_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_frame_ctrl_pkg.sv
// Shared constants and state encoding for the Hamming window frame controller.
// Coefficients are unsigned Q0.15, samples signed Q1.15.
package hamming_frame_ctrl_pkg;

   localparam int FRAME_LEN = 100;
   localparam int DATA_W    = 16;
   localparam int COEF_W    = 16;
   localparam int ROM_AW    = 7;

   localparam int FRAC_W = COEF_W - 1;
   localparam int PROD_W = DATA_W + COEF_W + 1;
   localparam logic signed [PROD_W-1:0] ROUND_K = PROD_W'(2**(FRAC_W-1));

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/hamming_frame_ctrl_win_mul_round.sv
// Combinational window multiply: signed sample x unsigned coefficient,
// round half up at the Q0.15 point, saturate back to the sample width.
module win_mul_round
   import hamming_frame_ctrl_pkg::*;
(
   input  logic signed [DATA_W-1:0] sample_i,
   input  logic        [COEF_W-1:0] coef_i,
   output logic signed [DATA_W-1:0] result_o
);

   localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(2**(DATA_W-1) - 1);
   localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] rounded;

   // Zero-extending the coefficient keeps it positive in the signed product.
   assign prod    = PROD_W'(sample_i) * PROD_W'($signed({1'b0, coef_i}));
   assign rounded = (prod + ROUND_K) >>> FRAC_W;

   always_comb begin
      result_o = rounded[DATA_W-1:0];
      if (rounded > SAT_MAX) begin
         result_o = SAT_MAX[DATA_W-1:0];
      end else if (rounded < SAT_MIN) begin
         result_o = SAT_MIN[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/hamming_frame_ctrl.sv
// Frame sequencer for the Hamming window ROM: accepts one frame of samples,
// windows each one and streams the result with a last marker.
module hamming_frame_ctrl
   import hamming_frame_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              clear,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [ROM_AW-1:0] rom_ad,
   output logic              rom_ce,
   output logic              rom_oce,
   output logic              rom_reset,
   input  logic [COEF_W-1:0] rom_dout,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done
);

   state_e                   state_q, state_d;
   logic [ROM_AW-1:0]        idx_q, idx_d;
   logic                     s1_valid_q, s1_last_q;
   logic signed [DATA_W-1:0] s1_data_q;
   logic [DATA_W-1:0]        m_data_q;
   logic                     m_valid_q, m_last_q;
   logic signed [DATA_W-1:0] win_res;
   logic                     adv, s_hs, last_hs;

   // One enable for every stage and the ROM keeps sample and coefficient aligned.
   assign adv     = !m_valid_q || m_ready;
   assign busy    = (state_q != S_IDLE);
   assign s_ready = (state_q == S_RUN) && adv && !clear;
   assign s_hs    = s_valid && s_ready;
   assign last_hs = s_hs && (idx_q == ROM_AW'(FRAME_LEN - 1));
   assign done    = (state_q == S_DRAIN) && m_valid_q && m_ready && m_last_q && !clear;

   assign rom_ad    = idx_q;
   assign rom_ce    = busy && adv;
   assign rom_oce   = 1'b1;
   assign rom_reset = 1'b0;

   assign m_data  = m_data_q;
   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;

   always_comb begin
      // NOTE: defaults first so every path assigns both signals and no latch is inferred.
      state_d = state_q;
      idx_d   = idx_q;
      if (clear) begin
         state_d = S_IDLE;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_RUN;
                  idx_d   = '0;
               end
            end
            S_RUN: begin
               if (s_hs) idx_d = idx_q + ROM_AW'(1);
               if (last_hs) state_d = S_DRAIN;
            end
            S_DRAIN: begin
               if (done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: non-blocking assignments for all registered state, so evaluation order never matters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   win_mul_round u_win_mul_round (
      .sample_i (s1_data_q),
      .coef_i   (rom_dout),
      .result_o (win_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_data_q  <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         m_data_q   <= '0;
      end else if (clear) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
      end else if (adv) begin
         s1_valid_q <= s_hs;
         s1_last_q  <= last_hs;
         if (s_hs) s1_data_q <= s_data;
         m_valid_q  <= s1_valid_q;
         m_last_q   <= s1_valid_q && s1_last_q;
         if (s1_valid_q) m_data_q <= win_res;
      end
   end

endmodule

// File: tb/tb_hamming_frame_ctrl.sv
// Directed bench for hamming_frame_ctrl with a behavioural window ROM,
// a negedge output monitor and a vector table for arithmetic corner cases.
module tb_hamming_frame_ctrl;

   localparam int N = 100;

   logic        clk, rst_n, start, clear, s_valid, s_ready;
   logic        rom_ce, rom_oce, rom_reset, m_valid, m_ready, m_last, busy, done;
   logic [15:0] s_data, rom_dout, m_data;
   logic [6:0]  rom_ad;

   typedef struct {
      int          idx;
      logic [15:0] sample;
      logic [15:0] coef_force;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs [12];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rmode    = 0;

   logic [15:0] coef_tab  [128];
   logic [15:0] force_tab [128];
   logic [15:0] samples   [N];
   logic [15:0] rom_q = '0;
   logic [15:0] out_q [$];
   logic        last_q [$];
   logic [15:0] ref_a [$];
   int hs_cnt, done_cnt, done_at, done_bad, ce_err, ad_err, first_hs_cyc, first_mv_cyc;

   hamming_frame_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .clear     (clear),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .rom_ad    (rom_ad),
      .rom_ce    (rom_ce),
      .rom_oce   (rom_oce),
      .rom_reset (rom_reset),
      .rom_dout  (rom_dout),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Window ROM model: one-cycle registered read, holds while CE is low.
   always @(posedge clk) begin
      if (rom_ce) rom_q <= (force_tab[rom_ad] != 16'h0) ? force_tab[rom_ad] : coef_tab[rom_ad];
   end
   assign rom_dout = rom_q;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (busy) begin
         if (rom_ce !== (!m_valid || m_ready)) ce_err++;
      end else if (rom_ce !== 1'b0) begin
         ce_err++;
      end
      if (s_valid && s_ready) begin
         if (rom_ad !== 7'(hs_cnt)) ad_err++;
         if (hs_cnt == 0) first_hs_cyc = cyc;
         hs_cnt++;
      end
      if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
      if (m_valid && m_ready) begin
         out_q.push_back(m_data);
         last_q.push_back(m_last);
      end
      if (done) begin
         done_cnt++;
         done_at = out_q.size();
         if (!(m_valid && m_ready && m_last)) done_bad++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got still running, expected finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] coef_at(input int a);
      return (force_tab[a] != 16'h0) ? force_tab[a] : coef_tab[a];
   endfunction

   function automatic logic [15:0] ref_win(input logic [15:0] s, input logic [15:0] c);
      longint p, r;
      p = longint'($signed(s)) * longint'(c);
      r = (p + 64'sd16384) >>> 15;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      return r[15:0];
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_m_data"},  m_data,  0);
      check({tag, "_m_valid"}, m_valid, 0);
      check({tag, "_m_last"},  m_last,  0);
      check({tag, "_s_ready"}, s_ready, 0);
      check({tag, "_done"},    done,    0);
      check({tag, "_busy"},    busy,    0);
      check({tag, "_rom_ad"},  rom_ad,  0);
      check({tag, "_rom_ce"},  rom_ce,  0);
   endtask

   task automatic clear_mon();
      out_q.delete();
      last_q.delete();
      hs_cnt = 0; done_cnt = 0; done_at = -1; done_bad = 0;
      ce_err = 0; ad_err = 0; first_hs_cyc = -1; first_mv_cyc = -1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_frame(input bit gap, input int rm, input bit poke);
      int i = 0, k = 0, budget = 5000, b2 = 3000;
      bit poked = 1'b0;
      rmode = rm;
      clear_mon();
      pulse_start();
      while (i < N && budget > 0) begin
         if (poke && i == 10 && !poked) begin
            poked   = 1'b1;
            s_valid = 1'b0;
            start   = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check("start_in_run_rom_ad", rom_ad, 10);
            check("start_in_run_busy", busy, 1);
         end
         s_valid = !(gap && (k % 3 == 2));
         s_data  = samples[i];
         @(negedge clk);
         if (s_valid && s_ready) i++;
         @(posedge clk);
         #1;
         k++;
         budget--;
      end
      s_valid = 1'b0;
      check("send_count", i, N);
      while (out_q.size() < N && b2 > 0) begin
         @(posedge clk);
         #1;
         b2--;
      end
      repeat (3) @(posedge clk);
      #1;
      rmode = 0;
   endtask

   task automatic check_frame(input string tag, input bit cmp_ref);
      int n_last = 0, bad_model = 0, bad_ref = 0, lim;
      logic l99;
      lim = (out_q.size() < N) ? out_q.size() : N;
      for (int i = 0; i < lim; i++) begin
         if (out_q[i] !== ref_win(samples[i], coef_at(i))) bad_model++;
         if (i < ref_a.size() && out_q[i] !== ref_a[i]) bad_ref++;
      end
      foreach (last_q[i]) if (last_q[i]) n_last++;
      l99 = (out_q.size() >= N) ? last_q[N-1] : 1'b0;
      check({tag, "_out_count"}, out_q.size(), N);
      check({tag, "_hs_count"}, hs_cnt, N);
      check({tag, "_model_mism"}, bad_model, 0);
      check({tag, "_last_count"}, n_last, 1);
      check({tag, "_last_at_99"}, l99, 1);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_done_with_last"}, done_at, N);
      check({tag, "_done_qual"}, done_bad, 0);
      check({tag, "_rom_ce_err"}, ce_err, 0);
      check({tag, "_rom_ad_err"}, ad_err, 0);
      check({tag, "_idle_after"}, busy, 0);
      if (cmp_ref) check({tag, "_ref_mism"}, bad_ref, 0);
   endtask

   initial begin
      int n_at, budget;
      logic [15:0] got;
      rst_n = 1'b0; start = 1'b0; clear = 1'b0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      for (int n = 0; n < 128; n++) begin
         real w;
         int  v;
         force_tab[n] = '0;
         coef_tab[n]  = '0;
         if (n < N) begin
            w = 0.54 - 0.46 * $cos(2.0 * 3.14159265358979 * n / 99.0);
            v = $rtoi(w * 32768.0 + 0.5);
            if (v > 32767) v = 32767;
            coef_tab[n] = 16'(v);
         end
      end
      vecs[0]  = '{0,  16'h8000, 16'h0000, 16'hF5C3};
      vecs[1]  = '{1,  16'h0000, 16'h0000, 16'h0000};
      vecs[2]  = '{2,  16'hFFFF, 16'h0000, 16'h0000};
      vecs[3]  = '{49, 16'h4000, 16'h0000, 16'h3FFC};
      vecs[4]  = '{50, 16'h8000, 16'h0000, 16'h8008};
      vecs[5]  = '{99, 16'h7FFF, 16'h0000, 16'h0A3D};
      vecs[6]  = '{60, 16'h7FFF, 16'hFFFF, 16'h7FFF};
      vecs[7]  = '{61, 16'h8000, 16'hFFFF, 16'h8000};
      vecs[8]  = '{62, 16'h4000, 16'h8000, 16'h4000};
      vecs[9]  = '{63, 16'h8000, 16'h8000, 16'h8000};
      vecs[10] = '{64, 16'h7FFF, 16'h8000, 16'h7FFF};
      vecs[11] = '{65, 16'h4000, 16'hFFFF, 16'h7FFF};

      #12;
      check_reset_outputs("por");
      check("por_rom_oce", rom_oce, 1);
      check("por_rom_reset", rom_reset, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full-scale frame, sink always ready.
      foreach (samples[i]) samples[i] = 16'h7FFF;
      run_frame(1'b0, 0, 1'b0);
      check_frame("a", 1'b0);
      check("a_out0",  (out_q.size() > 0)  ? out_q[0]  : 16'hxxxx, 16'h0A3D);
      check("a_out49", (out_q.size() > 49) ? out_q[49] : 16'hxxxx, 16'h7FF7);
      check("a_out99", (out_q.size() > 99) ? out_q[99] : 16'hxxxx, 16'h0A3D);
      check("a_latency", first_mv_cyc - first_hs_cyc, 2);
      ref_a = out_q;

      // Vector table: chosen samples and forced coefficients at fixed indices.
      foreach (vecs[v]) begin
         samples[vecs[v].idx]   = vecs[v].sample;
         force_tab[vecs[v].idx] = vecs[v].coef_force;
      end
      run_frame(1'b0, 0, 1'b0);
      foreach (vecs[v]) begin
         got = (out_q.size() > vecs[v].idx) ? out_q[vecs[v].idx] : 16'hxxxx;
         check($sformatf("vec%0d_idx%0d", v, vecs[v].idx), got, vecs[v].exp);
      end
      check_frame("b", 1'b0);
      foreach (force_tab[n]) force_tab[n] = '0;
      foreach (samples[i]) samples[i] = 16'h7FFF;

      // Random back-pressure, gapped input, start poke during RUN.
      run_frame(1'b0, 1, 1'b0);
      check_frame("c", 1'b1);
      run_frame(1'b1, 0, 1'b0);
      check_frame("d", 1'b1);
      run_frame(1'b0, 0, 1'b1);
      check_frame("e", 1'b1);

      // Abort mid-frame after output 40 has gone out.
      clear_mon();
      pulse_start();
      budget = 1000;
      while (out_q.size() < 41 && budget > 0) begin
         s_valid = 1'b1;
         s_data  = 16'h7FFF;
         @(posedge clk);
         #1;
         budget--;
      end
      clear   = 1'b1;
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("clr_busy", busy, 0);
      check("clr_m_valid", m_valid, 0);
      check("clr_out_seen", out_q.size() >= 41, 1);
      n_at = out_q.size();
      repeat (5) @(posedge clk);
      #1;
      check("clr_no_more_out", out_q.size(), n_at);
      check("clr_no_done", done_cnt, 0);
      check("clr_s_ready", s_ready, 0);
      run_frame(1'b0, 0, 1'b0);
      check("f_out0", (out_q.size() > 0) ? out_q[0] : 16'hxxxx, 16'h0A3D);
      check_frame("f", 1'b1);

      // Asynchronous reset while draining with the sink stalled.
      clear_mon();
      pulse_start();
      budget = 1000;
      n_at   = 0;
      while (n_at < N && budget > 0) begin
         s_valid = 1'b1;
         s_data  = 16'h7FFF;
         @(negedge clk);
         if (s_valid && s_ready) n_at++;
         @(posedge clk);
         #1;
         budget--;
      end
      s_valid = 1'b0;
      rmode   = 2;
      m_ready = 1'b0;
      check("drain_busy", busy, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      rmode = 0;
      @(posedge clk);
      #1;
      s_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_no_restart_busy", busy, 0);
      check("rst_no_restart_ready", s_ready, 0);
      check("rst_no_done", done_cnt, 0);
      s_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
